// File: rtl/imem_stream_loader_pkg.sv
// ============================================================================
// imem_stream_loader_pkg
// Shared defaults and encodings for the loadable fetch memory.
// Revision: 1.0
// ============================================================================
`default_nettype none

package imem_stream_loader_pkg;

  localparam int unsigned NB_INST_DEF   = 32;
  localparam int unsigned NB_BYTE_DEF   = 8;
  localparam int unsigned MEM_DEPTH_DEF = 128;
  localparam logic [31:0] HALT_WORD_DEF = 32'hF800_0000;
  localparam logic [31:0] NOP_WORD_DEF  = 32'h0000_0000;

  typedef enum logic [1:0] {
    ST_CLEAR = 2'd0,
    ST_LOAD  = 2'd1,
    ST_RUN   = 2'd2
  } state_e;

  // Selects what the fetch output presents.
  typedef enum logic [1:0] {
    SRC_NOP  = 2'd0,
    SRC_RAM  = 2'd1,
    SRC_HALT = 2'd2
  } out_src_e;

endpackage

`default_nettype wire

// File: rtl/imem_stream_loader_ram.sv
// ============================================================================
// imem_ram_1w1r
// Single write port, registered read port with enable; array is not reset.
// Revision: 1.0
// ============================================================================
`default_nettype none

module imem_ram_1w1r #(
  parameter int NB_DATA = 32,
  parameter int DEPTH   = 128,
  parameter int NB_ADDR = $clog2(DEPTH)
) (
  input  logic               i_clk,
  input  logic               i_we,
  input  logic [NB_ADDR-1:0] i_waddr,
  input  logic [NB_DATA-1:0] i_wdata,
  input  logic               i_re,
  input  logic [NB_ADDR-1:0] i_raddr,
  output logic [NB_DATA-1:0] o_rdata
);

  logic [NB_DATA-1:0] mem_q [DEPTH];
  logic [NB_DATA-1:0] rdata_q;
  logic [NB_DATA-1:0] rdata_d;

  // Read data holds while i_re is low so a stalled fetch keeps its word.
  always_comb begin
    rdata_d = rdata_q;
    if (i_re) begin
      rdata_d = mem_q[i_raddr];
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_we) begin
      mem_q[i_waddr] <= i_wdata;
    end
    rdata_q <= rdata_d;
  end

  assign o_rdata = rdata_q;

endmodule

`default_nettype wire

// File: rtl/imem_stream_loader.sv
// ============================================================================
// imem_stream_loader
// Fetch memory that self-clears to HALT, loads from a byte stream, then serves reads.
// Revision: 1.0
// ============================================================================
`default_nettype none

module imem_stream_loader
  import imem_stream_loader_pkg::*;
#(
  parameter int               NB_INST   = NB_INST_DEF,
  parameter int               NB_BYTE   = NB_BYTE_DEF,
  parameter int               MEM_DEPTH = MEM_DEPTH_DEF,
  parameter int               NB_ADDR   = $clog2(MEM_DEPTH),
  parameter logic [NB_INST-1:0] HALT_WORD = HALT_WORD_DEF,
  parameter logic [NB_INST-1:0] NOP_WORD  = NOP_WORD_DEF
) (
  input  logic               i_clk,
  input  logic               i_reset,
  input  logic               i_load_start,
  input  logic               i_load_end,
  input  logic               i_byte_valid,
  input  logic [NB_BYTE-1:0] i_byte,
  output logic               o_byte_ready,
  input  logic               i_rd_en,
  input  logic               i_flush,
  input  logic [NB_ADDR-1:0] i_rd_addr,
  output logic [NB_INST-1:0] o_inst,
  output logic               o_inst_valid,
  output logic               o_busy,
  output logic [NB_ADDR:0]   o_word_count,
  output logic               o_load_err
);

  localparam int                 BPW        = NB_INST / NB_BYTE;
  localparam int                 NB_BCNT    = $clog2(BPW + 1);
  localparam logic [NB_ADDR-1:0] LAST_ADDR  = NB_ADDR'(MEM_DEPTH - 1);
  localparam logic [NB_ADDR:0]   FULL_COUNT = (NB_ADDR + 1)'(MEM_DEPTH);
  localparam logic [NB_BCNT-1:0] LAST_BYTE  = NB_BCNT'(BPW - 1);

  state_e               state_q, state_d;
  logic [NB_ADDR-1:0]   clr_ptr_q, clr_ptr_d;
  logic [NB_BCNT-1:0]   byte_cnt_q, byte_cnt_d;
  logic [NB_INST-1:0]   word_buf_q, word_buf_d;
  logic [NB_ADDR:0]     word_count_q, word_count_d;
  logic                 load_err_q, load_err_d;
  out_src_e             src_q, src_d;
  logic                 inst_valid_q, inst_valid_d;

  logic                 full;
  logic                 byte_acc;
  logic                 rd_in_range;
  logic [NB_INST-1:0]   assembled;
  logic                 ram_we;
  logic [NB_ADDR-1:0]   ram_waddr;
  logic [NB_INST-1:0]   ram_wdata;
  logic                 ram_re;
  logic [NB_INST-1:0]   ram_rdata;

  assign full         = (word_count_q == FULL_COUNT);
  assign o_byte_ready = (state_q == ST_LOAD) && !full;
  assign byte_acc     = i_byte_valid && o_byte_ready;
  assign rd_in_range  = ({1'b0, i_rd_addr} < FULL_COUNT);
  assign o_busy       = (state_q == ST_CLEAR);

  // The new byte always enters at the bottom, so the first byte ends up on top.
  generate
    if (BPW > 1) begin : g_asm_shift
      assign assembled = {word_buf_q[NB_INST-NB_BYTE-1:0], i_byte};
    end else begin : g_asm_direct
      assign assembled = i_byte;
    end
  endgenerate

  always_comb begin
    state_d      = state_q;
    clr_ptr_d    = clr_ptr_q;
    byte_cnt_d   = byte_cnt_q;
    word_buf_d   = word_buf_q;
    word_count_d = word_count_q;
    load_err_d   = load_err_q;
    src_d        = src_q;
    inst_valid_d = inst_valid_q;
    ram_we       = 1'b0;
    ram_waddr    = clr_ptr_q;
    ram_wdata    = HALT_WORD;
    ram_re       = 1'b0;

    unique case (state_q)
      ST_CLEAR: begin
        src_d        = SRC_NOP;
        inst_valid_d = 1'b0;
        ram_we       = 1'b1;
        if (clr_ptr_q == LAST_ADDR) begin
          state_d   = ST_LOAD;
          clr_ptr_d = '0;
        end else begin
          clr_ptr_d = clr_ptr_q + NB_ADDR'(1);
        end
      end

      ST_LOAD: begin
        src_d        = SRC_NOP;
        inst_valid_d = 1'b0;
        if (byte_acc) begin
          if (byte_cnt_q == LAST_BYTE) begin
            ram_we       = 1'b1;
            ram_waddr    = word_count_q[NB_ADDR-1:0];
            ram_wdata    = assembled;
            word_count_d = word_count_q + (NB_ADDR + 1)'(1);
            byte_cnt_d   = '0;
          end else begin
            word_buf_d = assembled;
            byte_cnt_d = byte_cnt_q + NB_BCNT'(1);
          end
        end
        if (i_byte_valid && full) begin
          load_err_d = 1'b1;
        end
        // Partial check uses the count after this cycle's byte is taken.
        if (i_load_end) begin
          state_d = ST_RUN;
          if (byte_cnt_d != '0) begin
            load_err_d = 1'b1;
            byte_cnt_d = '0;
          end
        end
      end

      ST_RUN: begin
        if (i_flush) begin
          src_d        = SRC_NOP;
          inst_valid_d = 1'b0;
        end else if (i_rd_en) begin
          inst_valid_d = 1'b1;
          if (rd_in_range) begin
            ram_re = 1'b1;
            src_d  = SRC_RAM;
          end else begin
            src_d = SRC_HALT;
          end
        end
      end

      default: begin
        state_d = ST_CLEAR;
      end
    endcase

    if (i_load_start && (state_q != ST_CLEAR)) begin
      state_d      = ST_CLEAR;
      clr_ptr_d    = '0;
      byte_cnt_d   = '0;
      word_count_d = '0;
      load_err_d   = 1'b0;
      ram_we       = 1'b0;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q      <= ST_CLEAR;
      clr_ptr_q    <= '0;
      byte_cnt_q   <= '0;
      word_buf_q   <= '0;
      word_count_q <= '0;
      load_err_q   <= 1'b0;
      src_q        <= SRC_NOP;
      inst_valid_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      clr_ptr_q    <= clr_ptr_d;
      byte_cnt_q   <= byte_cnt_d;
      word_buf_q   <= word_buf_d;
      word_count_q <= word_count_d;
      load_err_q   <= load_err_d;
      src_q        <= src_d;
      inst_valid_q <= inst_valid_d;
    end
  end

  imem_ram_1w1r #(
    .NB_DATA (NB_INST),
    .DEPTH   (MEM_DEPTH),
    .NB_ADDR (NB_ADDR)
  ) u_ram (
    .i_clk   (i_clk),
    .i_we    (ram_we),
    .i_waddr (ram_waddr),
    .i_wdata (ram_wdata),
    .i_re    (ram_re),
    .i_raddr (i_rd_addr),
    .o_rdata (ram_rdata)
  );

  always_comb begin
    o_inst = NOP_WORD;
    unique case (src_q)
      SRC_RAM:  o_inst = ram_rdata;
      SRC_HALT: o_inst = HALT_WORD;
      default:  o_inst = NOP_WORD;
    endcase
  end

  assign o_inst_valid = inst_valid_q;
  assign o_word_count = word_count_q;
  assign o_load_err   = load_err_q;

endmodule

`default_nettype wire
